// File: rtl/bsg_profiler_pkg.sv
// Shared definitions for the profiler counter drain block.
package bsg_profiler_pkg;

  typedef enum logic [0:0] {
    eIdle  = 1'b0,
    eDrain = 1'b1
  } drain_state_e;

  // Index width that stays at least one bit wide for a single element.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_profiler_counter.sv
// One live event counter with synchronous clear and optional saturation.
module bsg_profiler_counter
  #(parameter int width_p    = 32,
    parameter int saturate_p = 1)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o);

  logic [width_p-1:0] count_r;
  logic [width_p-1:0] count_next_s;
  logic               at_max_s;

  // Next count: clear wins; a saturating counter holds at all-ones.
  always_comb begin
    at_max_s = (count_r == {width_p{1'b1}});
    if (clear_i) begin
      count_next_s = '0;
    end else if (inc_i && !((saturate_p != 0) && at_max_s)) begin
      count_next_s = count_r + width_p'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_profiler_counter_drain.sv
// Event counters that are snapshotted on request and drained one record per handshake.
module bsg_profiler_counter_drain
  import bsg_profiler_pkg::*;
  #(parameter int els_p      = 32,
    parameter int width_p    = 32,
    parameter int saturate_p = 1,
    localparam int lg_els_lp = safe_clog2(els_p))
  (input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [els_p-1:0]     countme_i,
   input  logic                 dump_v_i,
   output logic                 dump_ready_o,
   output logic                 v_o,
   input  logic                 ready_i,
   output logic [lg_els_lp-1:0] idx_o,
   output logic [width_p-1:0]   data_o,
   output logic                 last_o);

  localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

  drain_state_e         state_r, state_next_s;
  logic [lg_els_lp-1:0] index_r, index_next_s;
  logic [width_p-1:0]   live_s   [els_p];
  logic [width_p-1:0]   shadow_r [els_p];
  logic                 accept_s;
  logic                 last_s;

  // Same increment rule as the live counters, so the accept-cycle event lands in the snapshot.
  function automatic logic [width_p-1:0] bump(input logic [width_p-1:0] c, input logic inc);
    if (inc && !((saturate_p != 0) && (c == {width_p{1'b1}}))) begin
      return c + width_p'(1);
    end else begin
      return c;
    end
  endfunction

  assign accept_s = (state_r == eIdle) && dump_v_i;
  assign last_s   = (index_r == last_idx_lp);

  for (genvar i = 0; i < els_p; i++) begin : g_ctr
    bsg_profiler_counter #(.width_p(width_p), .saturate_p(saturate_p)) u_ctr
      (.clk_i   (clk_i),
       .reset_i (reset_i),
       .clear_i (accept_s),
       .inc_i   (countme_i[i]),
       .count_o (live_s[i]));
  end

  // Drain sequencing: one record per handshake, back to idle after the last one.
  always_comb begin
    state_next_s = state_r;
    index_next_s = index_r;
    case (state_r)
      eIdle: begin
        if (dump_v_i) begin
          state_next_s = eDrain;
          index_next_s = '0;
        end else begin
          state_next_s = eIdle;
        end
      end
      eDrain: begin
        if (ready_i) begin
          if (last_s) begin
            state_next_s = eIdle;
            index_next_s = '0;
          end else begin
            index_next_s = index_r + lg_els_lp'(1);
          end
        end else begin
          state_next_s = eDrain;
        end
      end
      default: begin
        state_next_s = eIdle;
        index_next_s = '0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIdle;
      index_r <= '0;
    end else begin
      state_r <= state_next_s;
      index_r <= index_next_s;
    end
  end

  // Snapshot registers, loaded only on an accepted dump.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) shadow_r[i] <= '0;
    end else if (accept_s) begin
      for (int i = 0; i < els_p; i++) shadow_r[i] <= bump(live_s[i], countme_i[i]);
    end else begin
      for (int i = 0; i < els_p; i++) shadow_r[i] <= shadow_r[i];
    end
  end

  assign dump_ready_o = (state_r == eIdle);
  assign v_o          = (state_r == eDrain);
  assign idx_o        = index_r;
  assign data_o       = shadow_r[index_r];
  assign last_o       = (state_r == eDrain) && last_s;

endmodule

// File: tb/tb_bsg_profiler_counter_drain.sv
// Bench: saturating, wrapping and single-element instances against a queue-based model.
module tb_bsg_profiler_counter_drain;

  logic       clk;
  logic       reset;
  logic [3:0] countme;
  logic       dump_v;
  logic       ready;

  logic       a_rdy, a_v, a_last;
  logic [1:0] a_idx;
  logic [7:0] a_data;
  logic       w_rdy, w_v, w_last;
  logic [1:0] w_idx;
  logic [7:0] w_data;
  logic       s_rdy, s_v, s_last;
  logic [0:0] s_idx;
  logic [7:0] s_data;

  int tests = 0;
  int fails = 0;

  bsg_profiler_counter_drain #(.els_p(4), .width_p(8), .saturate_p(1)) dut_a
    (.clk_i(clk), .reset_i(reset), .countme_i(countme), .dump_v_i(dump_v),
     .dump_ready_o(a_rdy), .v_o(a_v), .ready_i(ready), .idx_o(a_idx),
     .data_o(a_data), .last_o(a_last));

  bsg_profiler_counter_drain #(.els_p(4), .width_p(8), .saturate_p(0)) dut_w
    (.clk_i(clk), .reset_i(reset), .countme_i(countme), .dump_v_i(dump_v),
     .dump_ready_o(w_rdy), .v_o(w_v), .ready_i(ready), .idx_o(w_idx),
     .data_o(w_data), .last_o(w_last));

  bsg_profiler_counter_drain #(.els_p(1), .width_p(8), .saturate_p(1)) dut_s
    (.clk_i(clk), .reset_i(reset), .countme_i(countme[0]), .dump_v_i(dump_v),
     .dump_ready_o(s_rdy), .v_o(s_v), .ready_i(ready), .idx_o(s_idx),
     .data_o(s_data), .last_o(s_last));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: raw event counts since the last accept, and a queue of pending records per instance.
  typedef struct {int idx; int data;} rec_t;
  rec_t q_a[$];
  rec_t q_w[$];
  rec_t q_s[$];
  int   cnt[4];
  int   cnt_s;

  task automatic chk_port(input string nm, input logic v, input logic rdy, input int idx,
                          input int data, input logic last, input int qsz, input rec_t head,
                          input int els);
    check({nm, ".v_o"}, v, (qsz > 0));
    check({nm, ".dump_ready_o"}, rdy, (qsz == 0));
    if (qsz > 0) begin
      check({nm, ".idx_o"}, idx, head.idx);
      check({nm, ".data_o"}, data, head.data);
      check({nm, ".last_o"}, last, (head.idx == els - 1));
    end else begin
      check({nm, ".last_o"}, last, 0);
    end
  endtask

  function automatic rec_t head_of(input int sz, input rec_t h);
    rec_t z;
    z.idx = 0;
    z.data = 0;
    return (sz > 0) ? h : z;
  endfunction

  initial begin
    rec_t r, h;
    forever begin
      @(negedge clk);
      h = (q_a.size() > 0) ? q_a[0] : head_of(0, h);
      chk_port("sat", a_v, a_rdy, a_idx, a_data, a_last, q_a.size(), h, 4);
      h = (q_w.size() > 0) ? q_w[0] : head_of(0, h);
      chk_port("wrap", w_v, w_rdy, w_idx, w_data, w_last, q_w.size(), h, 4);
      h = (q_s.size() > 0) ? q_s[0] : head_of(0, h);
      chk_port("one", s_v, s_rdy, s_idx, s_data, s_last, q_s.size(), h, 1);
      // Advance the model with the inputs that the next rising edge will see.
      if (reset) begin
        q_a.delete(); q_w.delete(); q_s.delete();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        cnt_s = 0;
      end else begin
        if (q_a.size() == 0 && dump_v) begin
          for (int i = 0; i < 4; i++) begin
            r.idx = i;
            r.data = (cnt[i] + countme[i] > 255) ? 255 : cnt[i] + countme[i];
            q_a.push_back(r);
            r.data = (cnt[i] + countme[i]) % 256;
            q_w.push_back(r);
            cnt[i] = 0;
          end
        end else begin
          for (int i = 0; i < 4; i++) cnt[i] += countme[i];
          if (q_a.size() > 0 && ready) begin
            void'(q_a.pop_front());
            void'(q_w.pop_front());
          end
        end
        if (q_s.size() == 0 && dump_v) begin
          r.idx = 0;
          r.data = (cnt_s + countme[0] > 255) ? 255 : cnt_s + countme[0];
          q_s.push_back(r);
          cnt_s = 0;
        end else begin
          cnt_s += countme[0];
          if (q_s.size() > 0 && ready) void'(q_s.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int recs;
    reset = 1'b1; countme = 4'b0000; dump_v = 1'b0; ready = 1'b0;
    step(2);
    reset = 1'b0;
    check("rst.v_o", a_v, 0);
    check("rst.last_o", a_last, 0);
    check("rst.dump_ready_o", a_rdy, 1);
    check("rst.idx_o", a_idx, 0);
    check("rst.data_o", a_data, 0);

    // Three events on counter 0, two on counter 3, then dump.
    countme = 4'b0001; step(3);
    countme = 4'b1000; step(2);
    countme = 4'b0000; dump_v = 1'b1; step(1);
    dump_v = 1'b0;
    check("t1.first_v", a_v, 1);
    check("t1.idx0_data", a_data, 3);
    check("t1.one_data", s_data, 3);
    check("t1.one_last", s_last, 1);
    ready = 1'b1; step(1);
    check("t1.one_idle", s_rdy, 1);
    check("t1.idx1_data", a_data, 0);
    check("t1.idx1_last", a_last, 0);
    step(2);
    check("t1.idx3", a_idx, 3);
    check("t1.idx3_data", a_data, 2);
    check("t1.idx3_last", a_last, 1);
    step(1);
    check("t1.done_v", a_v, 0);

    // Events on all counters during the accept cycle land in the snapshot.
    ready = 1'b0; countme = 4'b1111; step(5);
    dump_v = 1'b1; step(1);
    dump_v = 1'b0;
    check("t2.shadow6", a_data, 6);
    step(1);
    countme = 4'b0000; ready = 1'b1; step(4);
    check("t2.drained", a_v, 0);
    dump_v = 1'b1; step(1);
    dump_v = 1'b0;
    check("t2.live1", a_data, 1);
    step(4);

    // Stall on idx 1 with ignored dump pulses.
    countme = 4'b0101; ready = 1'b0; step(2);
    countme = 4'b0000; dump_v = 1'b1; step(1);
    dump_v = 1'b0;
    check("t3.idx0_data", a_data, 2);
    ready = 1'b1; step(1);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dump_v = (k != 1);
      step(1);
      check("t3.hold_idx", a_idx, 1);
      check("t3.hold_data", a_data, 0);
      check("t3.hold_v", a_v, 1);
    end
    dump_v = 1'b0; ready = 1'b1;
    recs = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_v) recs++;
      step(1);
    end
    check("t3.records_left", recs, 3);

    // Reset mid-drain aborts, and the next dump is all zeros.
    countme = 4'b0010; step(2);
    countme = 4'b0000; dump_v = 1'b1; step(1);
    dump_v = 1'b0; step(2);
    check("t4.at_idx2", a_idx, 2);
    reset = 1'b1; step(1);
    reset = 1'b0;
    check("t4.abort_v", a_v, 0);
    check("t4.abort_ready", a_rdy, 1);
    dump_v = 1'b1; ready = 1'b0; step(1);
    dump_v = 1'b0;
    check("t4.zero_idx0", a_data, 0);
    ready = 1'b1; step(1);
    check("t4.zero_idx1", a_data, 0);
    step(3);

    // 300 events on counter 0: saturate vs. wrap.
    ready = 1'b0; countme = 4'b0001; step(300);
    countme = 4'b0000; dump_v = 1'b1; step(1);
    dump_v = 1'b0;
    check("t5.sat_data", a_data, 255);
    check("t5.wrap_data", w_data, 44);
    check("t5.one_sat", s_data, 255);
    ready = 1'b1; step(5);
    check("t5.idle", a_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_profiler_counter_drain.md
BSG_PROFILER_COUNTER_DRAIN -- requirements
Module: bsg_profiler_counter_drain

Interface
REQ-001 Parameter els_p, default 32, number of independent event counters.
REQ-002 Parameter width_p, default 32, bit width of each counter and of data_o.
REQ-003 Parameter saturate_p, default 1: 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^width_p.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset, synchronous and active-high.
REQ-006 countme_i  input  els_p  per-counter event strobe; bit i high adds 1 to counter i that cycle.
REQ-007 dump_v_i  input  1  snapshot-and-drain request.
REQ-008 dump_ready_o  output  1  high when a dump request is accepted this cycle if dump_v_i is high.
REQ-009 v_o  output  1  drained record valid.
REQ-010 ready_i  input  1  consumer ready; a record transfers when v_o & ready_i.
REQ-011 idx_o  output  lg(els_p)  counter index of the current record; width is BSG_SAFE_CLOG2(els_p).
REQ-012 data_o  output  width_p  snapshotted count of counter idx_o.
REQ-013 last_o  output  1  high with v_o when idx_o == els_p-1.

Function
REQ-014 Two states: eIdle, eDrain; dump_ready_o SHALL equal (state == eIdle).
REQ-015 Live counter i increments by countme_i[i] every cycle in both states, subject to the saturate/wrap rule.
REQ-016 Dump accept (eIdle & dump_v_i): shadow[i] <= live[i] + countme_i[i] (saturate/wrap applied); live[i] <= 0; state <= eDrain; index <= 0.
REQ-017 Events in the cycle after an accept count into the cleared live counter; no event is lost or double-counted across a snapshot.
REQ-018 In eDrain, v_o = 1, idx_o = index, data_o = shadow[index]; in eIdle, v_o = 0.
REQ-019 Handshake v_o & ready_i with index < els_p-1: index increments by 1 next cycle.
REQ-020 Handshake with index == els_p-1: state <= eIdle next cycle; index <= 0.
REQ-021 While v_o & ~ready_i, idx_o, data_o and last_o SHALL be held stable.
REQ-022 dump_v_i in eDrain SHALL be ignored (not queued); new accept requires at least one eIdle cycle after the final transfer.
REQ-023 Saturating mode: counter at 2^width_p-1 stays there on further events; wrap mode: rolls to 0.
REQ-024 Latency: first record valid the cycle after dump accept; drain of els_p records takes at least els_p cycles.
REQ-025 els_p == 1: single record with last_o = 1, then eIdle.

Reset
REQ-026 While reset_i is high: state <= eIdle, index <= 0, all live and shadow counters <= 0; countme_i and dump_v_i ignored.
REQ-027 Outputs after reset: v_o = 0, last_o = 0, dump_ready_o = 1, idx_o = 0, data_o = 0.
REQ-028 Reset asserted mid-drain SHALL abort the drain; no further records are emitted.

Structure
REQ-029 The state enum (eIdle, eDrain) SHALL reside in shared package bsg_profiler_pkg.
REQ-030 One sub-module bsg_profiler_counter (width_p, saturate_p; clk_i, reset_i, clear_i, inc_i, count_o) SHALL be instantiated els_p times.
REQ-031 Shadow registers and the drain index SHALL be in the top module; data_o is a mux of shadow by index.

Verification (els_p=4, width_p=8 unless stated)
REQ-032 Reset, then countme_i=4'b0001 for 3 cycles, 4'b1000 for 2 cycles, dump -> records (0,3),(1,0),(2,0),(3,2), last_o only on idx 3.
REQ-033 countme_i=4'b1111 held during the dump-accept cycle with live=5 each -> all shadows 6; live counters count 1 on the next event cycle.
REQ-034 saturate_p=1, 300 events on counter 0 -> data_o=255; saturate_p=0 -> data_o=44.
REQ-035 ready_i low 3 cycles on idx 1 -> idx_o=1 and data_o held; dump_v_i pulses during drain are ignored; exactly 4 records per dump.
REQ-036 reset_i pulsed after idx 1 transfers -> v_o=0 next cycle, dump_ready_o=1, subsequent dump returns all zeros.
REQ-037 els_p=1 -> single record with last_o=1, then dump_ready_o=1 next cycle.
